nx_instr_arbiter: RTL and testbench

Arbitrates one single-port instruction RAM between the instruction load stream and the fetch ports of two cores, with one RAM access per cycle. The RAM is split into two equal regions, one per core, and the block tracks how many instructions have been loaded into each. It sits between the inbound message decoder and the instruction RAM macro, and gives each core a stall-based fetch port.

---
 rtl/nx_instr_pkg.sv | 27 ++
 rtl/nx_instr_arbiter_rr.sv | 46 ++++
 rtl/nx_instr_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_nx_instr_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nx_instr_pkg.sv
// nx_instr_pkg: shared types and address-split helpers for the instruction
// RAM arbiter. The grant enum names the single RAM user of a cycle; the helper
// functions derive the region select bit and region depth from the RAM depth.
package nx_instr_pkg;

    typedef enum logic [1:0] {
        GRANT_NONE  = 2'd0,
        GRANT_LOAD  = 2'd1,
        GRANT_CORE0 = 2'd2,
        GRANT_CORE1 = 2'd3
    } grant_t;

    // Arbiter widths for the two build flavours: cores only, or load plus cores.
    localparam int ARB_PRIO_WAYS = 2;
    localparam int ARB_FAIR_WAYS = 3;

    // Bit position of the region (core) select inside a full RAM address.
    function automatic int region_bit(input int max_instrs);
        return $clog2(max_instrs) - 1;
    endfunction

    // Number of entries in one core's region.
    function automatic int region_depth(input int max_instrs);
        return max_instrs / 2;
    endfunction

endpackage

// File: rtl/nx_instr_arbiter_rr.sv
// nx_rr_arbiter: generic N-way round-robin arbiter. The pointer names the
// requester with highest priority; after a grant it moves to the requester just
// after the winner, so the winner becomes lowest priority. It resets to index 0.
module nx_rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);
    import nx_instr_pkg::*;

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] ptr;
    logic [IW-1:0] win;
    logic [IW-1:0] cand;
    logic          found;

    // Scan requesters starting at the pointer and grant the first one found.
    always_comb begin
        gnt   = '0;
        win   = '0;
        cand  = '0;
        found = 1'b0;
        for (int off = 0; off < N; off++) begin
            cand = IW'((int'(ptr) + off) % N);
            if (!found && req[cand]) begin
                gnt[cand] = 1'b1;
                win       = cand;
                found     = 1'b1;
            end
        end
    end

    // Advance the pointer past the winner, only in cycles that produced a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (int'(win) == N - 1) ? '0 : win + 1'b1;
        end
    end

endmodule

// File: rtl/nx_instr_arbiter.sv
// nx_instr_arbiter: shares one single-port instruction RAM between the load
// stream and the fetch ports of two cores, one access per cycle. Each core owns
// half of the RAM; per-region load counters saturate at the region depth, and a
// load to a full region is swallowed and raises the sticky overflow flag.
// Build option NX_INSTR_ARB_LOAD_PRIO_EN: when defined, loads have strict
// priority and the cores round-robin between themselves; when undefined, load,
// core 0 and core 1 share a 3-way rotating priority.
module nx_instr_arbiter
    import nx_instr_pkg::*;
#(
    parameter int INSTR_WIDTH = 15,
    parameter int MAX_INSTRS  = 512
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          store_core_i,
    input  logic [INSTR_WIDTH-1:0]        store_data_i,
    input  logic                          store_valid_i,
    output logic                          store_ready_o,
    output logic [$clog2(MAX_INSTRS)-1:0] core_0_populated_o,
    output logic [$clog2(MAX_INSTRS)-1:0] core_1_populated_o,
    output logic                          overflow_o,
    input  logic [$clog2(MAX_INSTRS)-2:0] core_0_addr_i,
    input  logic                          core_0_rd_i,
    output logic [INSTR_WIDTH-1:0]        core_0_data_o,
    output logic                          core_0_stall_o,
    input  logic [$clog2(MAX_INSTRS)-2:0] core_1_addr_i,
    input  logic                          core_1_rd_i,
    output logic [INSTR_WIDTH-1:0]        core_1_data_o,
    output logic                          core_1_stall_o,
    output logic [$clog2(MAX_INSTRS)-1:0] ram_addr_o,
    output logic                          ram_wr_en_o,
    output logic [INSTR_WIDTH-1:0]        ram_wr_data_o,
    output logic                          ram_rd_en_o,
    input  logic [INSTR_WIDTH-1:0]        ram_rd_data_i
);

    localparam int AW           = $clog2(MAX_INSTRS);
    localparam int OW           = region_bit(MAX_INSTRS);
    localparam int REGION_DEPTH = region_depth(MAX_INSTRS);

    logic [AW-1:0]          pop0;
    logic [AW-1:0]          pop1;
    logic                   overflow;
    logic                   tag_valid;
    logic                   tag_core;
    logic [INSTR_WIDTH-1:0] hold0;
    logic [INSTR_WIDTH-1:0] hold1;

    logic [AW-1:0]          target_count;
    logic                   target_full;
    logic                   load_req;
    logic                   drop;
    logic                   c0_req;
    logic                   c1_req;
    grant_t                 grant;

    // Requests are masked during reset so nothing is granted or accepted.
    assign target_count = store_core_i ? pop1 : pop0;
    assign target_full  = (target_count == AW'(REGION_DEPTH));
    assign load_req     = store_valid_i & ~target_full & ~rst_i;
    assign drop         = store_valid_i &  target_full & ~rst_i;
    assign c0_req       = core_0_rd_i & ~rst_i;
    assign c1_req       = core_1_rd_i & ~rst_i;

`ifdef NX_INSTR_ARB_LOAD_PRIO_EN
    logic [ARB_PRIO_WAYS-1:0] core_req;
    logic [ARB_PRIO_WAYS-1:0] core_gnt;

    // A pending load hides the cores from the arbiter, so its pointer only moves on core grants.
    assign core_req = {c1_req & ~load_req, c0_req & ~load_req};

    nx_rr_arbiter #(
        .N(ARB_PRIO_WAYS)
    ) u_arb (
        .clk (clk_i),
        .rst (rst_i),
        .req (core_req),
        .gnt (core_gnt)
    );

    // Load wins outright; otherwise the core arbiter decides.
    always_comb begin
        grant = GRANT_NONE;
        if (load_req) begin
            grant = GRANT_LOAD;
        end else if (core_gnt[0]) begin
            grant = GRANT_CORE0;
        end else if (core_gnt[1]) begin
            grant = GRANT_CORE1;
        end
    end
`else
    logic [ARB_FAIR_WAYS-1:0] arb_req;
    logic [ARB_FAIR_WAYS-1:0] arb_gnt;

    // Index 0 is the load stream, so the reset priority order is load, core 0, core 1.
    assign arb_req = {c1_req, c0_req, load_req};

    nx_rr_arbiter #(
        .N(ARB_FAIR_WAYS)
    ) u_arb (
        .clk (clk_i),
        .rst (rst_i),
        .req (arb_req),
        .gnt (arb_gnt)
    );

    // Translate the one-hot fair grant into the grant enum.
    always_comb begin
        grant = GRANT_NONE;
        if (arb_gnt[0]) begin
            grant = GRANT_LOAD;
        end else if (arb_gnt[1]) begin
            grant = GRANT_CORE0;
        end else if (arb_gnt[2]) begin
            grant = GRANT_CORE1;
        end
    end
`endif

    // Drive the RAM port and the load handshake from the winning requester.
    always_comb begin
        ram_addr_o    = '0;
        ram_wr_en_o   = 1'b0;
        ram_wr_data_o = '0;
        ram_rd_en_o   = 1'b0;
        store_ready_o = drop;
        unique case (grant)
            GRANT_LOAD: begin
                ram_wr_en_o   = 1'b1;
                ram_addr_o    = {store_core_i, target_count[OW-1:0]};
                ram_wr_data_o = store_data_i;
                store_ready_o = 1'b1;
            end
            GRANT_CORE0: begin
                ram_rd_en_o = 1'b1;
                ram_addr_o  = {1'b0, core_0_addr_i};
            end
            GRANT_CORE1: begin
                ram_rd_en_o = 1'b1;
                ram_addr_o  = {1'b1, core_1_addr_i};
            end
            default: begin
                ram_rd_en_o = 1'b0;
            end
        endcase
    end

    assign core_0_stall_o = core_0_rd_i & (grant != GRANT_CORE0);
    assign core_1_stall_o = core_1_rd_i & (grant != GRANT_CORE1);

    // Counters, overflow flag, read owner tag and per-core hold registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pop0      <= '0;
            pop1      <= '0;
            overflow  <= 1'b0;
            tag_valid <= 1'b0;
            tag_core  <= 1'b0;
            hold0     <= '0;
            hold1     <= '0;
        end else begin
            if (grant == GRANT_LOAD) begin
                if (store_core_i) begin
                    pop1 <= pop1 + 1'b1;
                end else begin
                    pop0 <= pop0 + 1'b1;
                end
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            tag_valid <= (grant == GRANT_CORE0) || (grant == GRANT_CORE1);
            tag_core  <= (grant == GRANT_CORE1);
            if (tag_valid) begin
                if (tag_core) begin
                    hold1 <= ram_rd_data_i;
                end else begin
                    hold0 <= ram_rd_data_i;
                end
            end
        end
    end

    // The returning word bypasses the hold register in its first cycle; reset forces zero.
    assign core_0_data_o = rst_i ? '0 :
                           (tag_valid && !tag_core) ? ram_rd_data_i : hold0;
    assign core_1_data_o = rst_i ? '0 :
                           (tag_valid &&  tag_core) ? ram_rd_data_i : hold1;

    assign core_0_populated_o = pop0;
    assign core_1_populated_o = pop1;
    assign overflow_o         = overflow;

endmodule

// File: tb/tb_nx_instr_arbiter.sv
// tb_nx_instr_arbiter: randomized and directed stimulus against a behavioural
// model of the arbiter (priority list rotation, region counts, RAM image).
// Honours NX_INSTR_ARB_LOAD_PRIO_EN the same way as the design.
module tb_nx_instr_arbiter;

    localparam int IW    = 15;
    localparam int MAX   = 512;
    localparam int AW    = 9;
    localparam int OW    = 8;
    localparam int DEPTH = 256;

    localparam int G_NONE = 0;
    localparam int G_LOAD = 1;
    localparam int G_C0   = 2;
    localparam int G_C1   = 3;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          store_core_i;
    logic [IW-1:0] store_data_i;
    logic          store_valid_i;
    logic          store_ready_o;
    logic [AW-1:0] core_0_populated_o;
    logic [AW-1:0] core_1_populated_o;
    logic          overflow_o;
    logic [OW-1:0] core_0_addr_i;
    logic          core_0_rd_i;
    logic [IW-1:0] core_0_data_o;
    logic          core_0_stall_o;
    logic [OW-1:0] core_1_addr_i;
    logic          core_1_rd_i;
    logic [IW-1:0] core_1_data_o;
    logic          core_1_stall_o;
    logic [AW-1:0] ram_addr_o;
    logic          ram_wr_en_o;
    logic [IW-1:0] ram_wr_data_o;
    logic          ram_rd_en_o;
    logic [IW-1:0] ram_rd_data_i;

    int checks = 0;
    int errors = 0;

    logic [IW-1:0] ram_mem [MAX];
    logic [IW-1:0] exp_mem [MAX];

    int            m_pop [2];
    bit            m_ovf;
    int            m_order [$];
    logic [IW-1:0] m_hold [2];
    bit            m_pend_v;
    int            m_pend_core;
    logic [IW-1:0] m_pend_data;

    bit last_ready;
    bit last_stall0;
    bit last_stall1;

    bit            d_sv;
    bit            d_sc;
    logic [IW-1:0] d_sd;
    bit            d_r0;
    bit            d_r1;
    logic [OW-1:0] d_a0;
    logic [OW-1:0] d_a1;

    nx_instr_arbiter #(
        .INSTR_WIDTH (IW),
        .MAX_INSTRS  (MAX)
    ) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .store_core_i       (store_core_i),
        .store_data_i       (store_data_i),
        .store_valid_i      (store_valid_i),
        .store_ready_o      (store_ready_o),
        .core_0_populated_o (core_0_populated_o),
        .core_1_populated_o (core_1_populated_o),
        .overflow_o         (overflow_o),
        .core_0_addr_i      (core_0_addr_i),
        .core_0_rd_i        (core_0_rd_i),
        .core_0_data_o      (core_0_data_o),
        .core_0_stall_o     (core_0_stall_o),
        .core_1_addr_i      (core_1_addr_i),
        .core_1_rd_i        (core_1_rd_i),
        .core_1_data_o      (core_1_data_o),
        .core_1_stall_o     (core_1_stall_o),
        .ram_addr_o         (ram_addr_o),
        .ram_wr_en_o        (ram_wr_en_o),
        .ram_wr_data_o      (ram_wr_data_o),
        .ram_rd_en_o        (ram_rd_en_o),
        .ram_rd_data_i      (ram_rd_data_i)
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    // Single-port RAM with one cycle of read latency.
    always @(posedge clk_i) begin
        if (ram_wr_en_o) ram_mem[ram_addr_o] <= ram_wr_data_o;
        if (ram_rd_en_o) ram_rd_data_i <= ram_mem[ram_addr_o];
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic resetOrder();
        m_order.delete();
`ifdef NX_INSTR_ARB_LOAD_PRIO_EN
        m_order.push_back(G_C0);
        m_order.push_back(G_C1);
`else
        m_order.push_back(G_LOAD);
        m_order.push_back(G_C0);
        m_order.push_back(G_C1);
`endif
    endtask

    task automatic applyStimulus(input bit r, input bit sv, input bit sc, input logic [IW-1:0] sd,
                                 input bit rd0, input logic [OW-1:0] a0,
                                 input bit rd1, input logic [OW-1:0] a1);
        @(posedge clk_i);
        #1;
        rst_i         = r;
        store_valid_i = sv;
        store_core_i  = sc;
        store_data_i  = sd;
        core_0_rd_i   = rd0;
        core_0_addr_i = a0;
        core_1_rd_i   = rd1;
        core_1_addr_i = a1;
    endtask

    // Behavioural model: check every output on the falling edge, then advance the model by one cycle.
    always @(negedge clk_i) begin : compare_proc
        int g;
        int x;
        int sc;
        int e_addr;
        int e_d0;
        int e_d1;
        bit load_req;
        bit drop;
        bit req [4];
        g        = G_NONE;
        x        = 0;
        sc       = int'(store_core_i);
        e_addr   = 0;
        load_req = 1'b0;
        drop     = 1'b0;
        req[G_NONE] = 1'b0;
        req[G_LOAD] = 1'b0;
        req[G_C0]   = 1'b0;
        req[G_C1]   = 1'b0;
        if (!rst_i) begin
            load_req    = store_valid_i && (m_pop[sc] < DEPTH);
            drop        = store_valid_i && (m_pop[sc] == DEPTH);
            req[G_LOAD] = load_req;
            req[G_C0]   = core_0_rd_i;
            req[G_C1]   = core_1_rd_i;
`ifdef NX_INSTR_ARB_LOAD_PRIO_EN
            if (load_req) g = G_LOAD;
`endif
            for (int i = 0; i < m_order.size(); i++) begin
                if (g == G_NONE && req[m_order[i]]) g = m_order[i];
            end
        end
        if (g == G_LOAD) e_addr = sc * DEPTH + m_pop[sc];
        if (g == G_C0)   e_addr = int'(core_0_addr_i);
        if (g == G_C1)   e_addr = DEPTH + int'(core_1_addr_i);

        e_d0 = rst_i ? 0 : ((m_pend_v && m_pend_core == 0) ? int'(m_pend_data) : int'(m_hold[0]));
        e_d1 = rst_i ? 0 : ((m_pend_v && m_pend_core == 1) ? int'(m_pend_data) : int'(m_hold[1]));

        checkOutput("store_ready", int'(store_ready_o), int'(g == G_LOAD || drop));
        checkOutput("ram_wr_en",   int'(ram_wr_en_o),   int'(g == G_LOAD));
        checkOutput("ram_rd_en",   int'(ram_rd_en_o),   int'(g == G_C0 || g == G_C1));
        if (g != G_NONE) checkOutput("ram_addr", int'(ram_addr_o), e_addr);
        if (g == G_LOAD) checkOutput("ram_wr_data", int'(ram_wr_data_o), int'(store_data_i));
        checkOutput("core0_stall", int'(core_0_stall_o), int'(core_0_rd_i && g != G_C0));
        checkOutput("core1_stall", int'(core_1_stall_o), int'(core_1_rd_i && g != G_C1));
        checkOutput("core0_data",  int'(core_0_data_o), e_d0);
        checkOutput("core1_data",  int'(core_1_data_o), e_d1);
        checkOutput("core0_pop",   int'(core_0_populated_o), m_pop[0]);
        checkOutput("core1_pop",   int'(core_1_populated_o), m_pop[1]);
        checkOutput("overflow",    int'(overflow_o), int'(m_ovf));

        last_ready  = store_ready_o;
        last_stall0 = core_0_stall_o;
        last_stall1 = core_1_stall_o;

        if (rst_i) begin
            m_pop[0]  = 0;
            m_pop[1]  = 0;
            m_ovf     = 1'b0;
            m_hold[0] = '0;
            m_hold[1] = '0;
            m_pend_v  = 1'b0;
            resetOrder();
        end else begin
            if (m_pend_v) m_hold[m_pend_core] = m_pend_data;
            m_pend_v = (g == G_C0 || g == G_C1);
            if (m_pend_v) begin
                m_pend_core = (g == G_C1) ? 1 : 0;
                m_pend_data = exp_mem[e_addr];
            end
            if (g == G_LOAD) begin
                exp_mem[e_addr] = store_data_i;
                m_pop[sc]++;
            end
            if (drop) m_ovf = 1'b1;
            if (g != G_NONE) begin
                for (int i = 0; i < m_order.size(); i++) begin
                    if (m_order[i] == g) x = 1;
                end
                if (x == 1) begin
                    do begin
                        x = m_order.pop_front();
                        m_order.push_back(x);
                    end while (x != g);
                end
            end
        end
    end

    // Directed scenarios followed by constrained-random traffic.
    initial begin
        int k;
        for (int i = 0; i < MAX; i++) begin
            ram_mem[i] = IW'(i * 37 + 5);
            exp_mem[i] = IW'(i * 37 + 5);
        end
        resetOrder();
        rst_i = 1'b1; store_valid_i = 1'b0; store_core_i = 1'b0; store_data_i = '0;
        core_0_rd_i = 1'b0; core_0_addr_i = '0; core_1_rd_i = 1'b0; core_1_addr_i = '0;
        applyStimulus(1, 0, 0, '0, 0, '0, 0, '0);
        applyStimulus(1, 0, 0, '0, 0, '0, 0, '0);
        applyStimulus(0, 0, 0, '0, 0, '0, 0, '0);
        @(negedge clk_i); #1;
        checkOutput("lit_reset_pop0", int'(core_0_populated_o), 0);
        checkOutput("lit_reset_data0", int'(core_0_data_o), 0);

        $display("[TB] uncontested loads");
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, IW'(100 + i), 0, '0, 0, '0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, IW'(200 + i), 0, '0, 0, '0);
        applyStimulus(0, 0, 0, '0, 0, '0, 0, '0);
        @(negedge clk_i); #1;
        checkOutput("lit_pop0_4", int'(core_0_populated_o), 4);
        checkOutput("lit_pop1_3", int'(core_1_populated_o), 3);
        checkOutput("lit_ram0", int'(ram_mem[0]), 100);
        checkOutput("lit_ram3", int'(ram_mem[3]), 103);
        checkOutput("lit_ram256", int'(ram_mem[256]), 200);
        checkOutput("lit_ram258", int'(ram_mem[258]), 202);

        $display("[TB] both cores reading");
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, '0, 1, 8'd1, 1, 8'd2);
        applyStimulus(0, 0, 0, '0, 0, '0, 0, '0);
        @(negedge clk_i); #1;
        checkOutput("lit_core0_word", int'(core_0_data_o), 101);
        checkOutput("lit_core1_word", int'(core_1_data_o), 202);

        $display("[TB] load against core 0 read");
        k = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 1, 0, IW'(300 + k), 1, 8'd0, 0, '0);
            @(negedge clk_i); #1;
            if (last_ready) k++;
        end
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, '0, 1, 8'd0, 0, '0);
        applyStimulus(0, 0, 0, '0, 0, '0, 0, '0);

        $display("[TB] fill core 1 region");
        for (int i = 0; i < DEPTH - 3; i++) applyStimulus(0, 1, 1, IW'($urandom), 0, '0, 0, '0);
        applyStimulus(0, 1, 1, IW'(12345), 0, '0, 0, '0);
        applyStimulus(0, 0, 0, '0, 0, '0, 0, '0);
        @(negedge clk_i); #1;
        checkOutput("lit_pop1_full", int'(core_1_populated_o), DEPTH);
        checkOutput("lit_overflow_set", int'(overflow_o), 1);

        $display("[TB] random traffic");
        d_sv = 1'b0; d_r0 = 1'b0; d_r1 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_i); #1;
            if (!(d_sv && !last_ready)) begin
                d_sv = ($urandom_range(0, 2) != 0);
                d_sc = 1'($urandom_range(0, 1));
                d_sd = IW'($urandom);
            end
            if (!(d_r0 && last_stall0)) begin
                d_r0 = 1'($urandom_range(0, 1));
                d_a0 = OW'($urandom);
            end
            if (!(d_r1 && last_stall1)) begin
                d_r1 = 1'($urandom_range(0, 1));
                d_a1 = OW'($urandom);
            end
            applyStimulus(0, d_sv, d_sc, d_sd, d_r0, d_a0, d_r1, d_a1);
        end
        applyStimulus(0, 0, 0, '0, 0, '0, 0, '0);
        @(negedge clk_i); #1;
        checkOutput("lit_overflow_sticky", int'(overflow_o), 1);

        $display("[TB] reset behind a core 0 read");
        applyStimulus(0, 0, 0, '0, 1, 8'd1, 0, '0);
        applyStimulus(1, 0, 0, '0, 0, '0, 0, '0);
        applyStimulus(0, 0, 0, '0, 0, '0, 0, '0);
        @(negedge clk_i); #1;
        checkOutput("lit_rst_data0", int'(core_0_data_o), 0);
        checkOutput("lit_rst_pop0", int'(core_0_populated_o), 0);
        checkOutput("lit_rst_pop1", int'(core_1_populated_o), 0);
        checkOutput("lit_rst_overflow", int'(overflow_o), 0);

        d_sv = 1'b0; d_r0 = 1'b0; d_r1 = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_i); #1;
            if (!(d_sv && !last_ready)) begin
                d_sv = 1'($urandom_range(0, 1));
                d_sc = 1'($urandom_range(0, 1));
                d_sd = IW'($urandom);
            end
            if (!(d_r0 && last_stall0)) begin
                d_r0 = 1'($urandom_range(0, 1));
                d_a0 = OW'($urandom_range(0, 7));
            end
            if (!(d_r1 && last_stall1)) begin
                d_r1 = 1'($urandom_range(0, 1));
                d_a1 = OW'($urandom_range(0, 7));
            end
            applyStimulus(0, d_sv, d_sc, d_sd, d_r0, d_a0, d_r1, d_a1);
        end
        applyStimulus(0, 0, 0, '0, 0, '0, 0, '0);
        @(negedge clk_i); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
